mult_hilo_ctrl: RTL and testbench

//  Issue-side sequencer for the iterative shift-add integer multiplier (int_multiplier).

---
 rtl/mult_hilo_ctrl.sv | 157 +++++++++++++++
 tb/tb_mult_hilo_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_ctrl.sv
// Issue-side sequencer for the iterative shift-add multiplier: launches MULT/MULTU, owns HI/LO.
// Optional signed support is compiled in with `define SIGNED_MULT_EN.
module mult_hilo_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               mt_hi,
  input  logic               mt_lo,
  input  logic [WIDTH-1:0]   mt_data,
  input  logic               mf_req,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               done,
  output logic               stall
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_CAPT  = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mul_start_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   mul_a_q;
  logic [WIDTH-1:0]   mul_b_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic [2*WIDTH-1:0] prod_fix_d;

`ifdef SIGNED_MULT_EN
  logic neg_d;
  logic neg_q;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Magnitudes go to the unsigned multiplier; the result sign is restored at capture.
  always_comb begin
    if (is_signed) begin
      a_mag_d = abs_val(op_a);
      b_mag_d = abs_val(op_b);
      neg_d   = op_a[WIDTH-1] ^ op_b[WIDTH-1];
    end else begin
      a_mag_d = op_a;
      b_mag_d = op_b;
      neg_d   = 1'b0;
    end
    if (neg_q) begin
      prod_fix_d = ~mul_product + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      prod_fix_d = mul_product;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (state_q == S_IDLE && req) begin
      neg_q <= neg_d;
    end else begin
      neg_q <= neg_q;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag_d          = op_a;
  assign b_mag_d          = op_b;
  assign prod_fix_d       = mul_product;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A request takes priority; a coincident MTHI/MTLO is dropped.
          if (req) begin
            mul_a_q     <= a_mag_d;
            mul_b_q     <= b_mag_d;
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_START;
          end else begin
            if (mt_hi) hi_q <= mt_data;
            if (mt_lo) lo_q <= mt_data;
          end
        end
        S_START: begin
          mul_start_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= S_RUN;
        end
        S_RUN: begin
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_CAPT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_CAPT: begin
          {hi_q, lo_q} <= prod_fix_d;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          mul_start_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign stall     = busy_q & (req | mt_hi | mt_lo | mf_req);

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl with a behavioural shift-add multiplier (one bit per cycle after start).
module tb_mult_hilo_ctrl;
  localparam int W = 32;
`ifdef SIGNED_MULT_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic          clk, rst, req, is_signed, mt_hi, mt_lo, mf_req;
  logic [W-1:0]  op_a, op_b, mt_data;
  logic          mul_start, busy, done, stall;
  logic [W-1:0]  mul_a, mul_b, hi, lo;
  logic [2*W-1:0] mul_product;

  int tests = 0;
  int fails = 0;

  mult_hilo_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .mt_hi(mt_hi), .mt_lo(mt_lo),
    .mt_data(mt_data), .mf_req(mf_req), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Iterative multiplier model: product only complete WIDTH cycles after start.
  logic [2*W-1:0] m_acc = '0;
  int             m_cnt = W;
  assign mul_product = m_acc;
  always @(posedge clk) begin
    if (mul_start) begin
      m_acc <= '0;
      m_cnt <= 0;
    end else if (m_cnt < W) begin
      if (mul_b[m_cnt]) m_acc <= m_acc + ((2*W)'(mul_a) << m_cnt);
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mag(input logic s, input logic [W-1:0] v);
    if (SGN && s && v[W-1]) return ~v + 32'd1;
    return v;
  endfunction

  // mode 0: plain; mode 1: inject req/mt/mf at T+5; mode 2: mt_hi alongside req
  task automatic do_mult(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] prod, input int mode, input logic [W-1:0] hi_mid);
    int cyc;
    int viol;
    @(negedge clk);
    req = 1'b1; is_signed = s; op_a = a; op_b = b;
    if (mode == 2) begin mt_hi = 1'b1; mt_data = 32'h0000BEEF; end
    cyc = 0;
    viol = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req = 1'b0; mt_hi = 1'b0;
        chk("start_pulse", 64'(mul_start), 64'd1);
        chk("busy_start", 64'(busy), 64'd1);
        chk("mul_a", 64'(mul_a), 64'(mag(s, a)));
        chk("mul_b", 64'(mul_b), 64'(mag(s, b)));
        if (mode == 2) chk("hi_kept_on_req", 64'(hi), 64'(hi_mid));
      end
      if (cyc == 2) chk("start_low", 64'(mul_start), 64'd0);
      if (mode == 1 && cyc == 5) begin
        req = 1'b1; op_a = 32'd9; op_b = 32'd9; mt_hi = 1'b1; mt_lo = 1'b1;
        mt_data = 32'h0000DEAD; mf_req = 1'b1;
        #1;
        chk("stall_busy", 64'(stall), 64'd1);
      end
      if (mode == 1 && cyc == 6) begin
        req = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; mf_req = 1'b0;
        chk("hi_busy_hold", 64'(hi), 64'(hi_mid));
        chk("mul_a_hold", 64'(mul_a), 64'(mag(s, a)));
      end
      if (cyc >= 1 && cyc <= W + 2 && !busy) viol++;
    end while (!done && cyc < 100);
    chk("busy_window", 64'(viol), 64'd0);
    chk("latency", 64'(cyc), 64'(W + 3));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("hi", 64'(hi), 64'(prod[63:32]));
    chk("lo", 64'(lo), 64'(prod[31:0]));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [63:0]  prod;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    int nd;
    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000005,
                SGN ? 64'hFFFFFFFF_FFFFFFF1 : 64'h00000004_FFFFFFF1};
    vecs[2] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[3] = '{1'b1, 32'h00000007, 32'hFFFFFFFF,
                SGN ? 64'hFFFFFFFF_FFFFFFF9 : 64'h00000006_FFFFFFF9};
    vecs[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                SGN ? 64'h00000000_00000001 : 64'hFFFFFFFE_00000001};
    vecs[5] = '{1'b1, 32'h00000000, 32'hFFFFFFFB, 64'h00000000_00000000};
    vecs[6] = '{1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000};

    rst = 1'b1; req = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0; mf_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_start", 64'(mul_start), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0; mf_req = 1'b0;

    for (int i = 0; i < NV; i++)
      do_mult(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].prod, 0, 32'd0);

    // Requests/writes during a multiply are stalled and ignored.
    do_mult(1'b0, 32'd3, 32'd4, 64'd12, 1, vecs[NV-1].prod[63:32]);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_replay_done", 64'(nd), 64'd0);
    chk("no_replay_hi", 64'(hi), 64'd0);
    chk("no_replay_lo", 64'(lo), 64'd12);
    mf_req = 1'b1;
    #1;
    chk("stall_idle", 64'(stall), 64'd0);
    mf_req = 1'b0;

    // Reset ten cycles into a multiply.
    @(negedge clk);
    req = 1'b1; is_signed = 1'b0; op_a = 32'd100; op_b = 32'd100;
    @(negedge clk);
    req = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_mul_a", 64'(mul_a), 64'd0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", 64'(nd), 64'd0);
    do_mult(1'b0, 32'd6, 32'd7, 64'd42, 0, 32'd0);

    // MTHI/MTLO in IDLE.
    @(negedge clk);
    mt_hi = 1'b1; mt_data = 32'hCAFE0001;
    @(negedge clk);
    mt_hi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'hCAFE0001);
    chk("mthi_lo", 64'(lo), 64'd42);
    mt_lo = 1'b1; mt_data = 32'h00001234;
    @(negedge clk);
    mt_lo = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h1234);
    chk("mtlo_hi", 64'(hi), 64'hCAFE0001);
    mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'hA5A5A5A5;
    @(negedge clk);
    mt_hi = 1'b0; mt_lo = 1'b0;
    chk("mtboth_hi", 64'(hi), 64'hA5A5A5A5);
    chk("mtboth_lo", 64'(lo), 64'hA5A5A5A5);
    do_mult(1'b0, 32'd2, 32'd3, 64'd6, 2, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
